// File: rtl/equiv_sweep_ctrl.sv
`default_nettype none
// equiv_sweep_ctrl: exhaustively sweeps the shared input vector of two N-input functions,
// compares their outputs after LAT cycles, counts mismatches and captures the first failing vector.
module equiv_sweep_ctrl #(
  parameter int N   = 3,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         stop_on_fail,
  output logic [N-1:0] vec,
  output logic         vec_valid,
  input  logic         q_a,
  input  logic         q_b,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         fail_valid,
  output logic [N-1:0] fail_vec,
  output logic [N:0]   mismatch_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         DW         = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [N:0] LAST_IDX   = {1'b0, {N{1'b1}}};
  localparam logic [N:0] MAX_COUNT  = {1'b1, {N{1'b0}}};
  localparam logic [N:0] ONE        = {{N{1'b0}}, 1'b1};
  localparam logic [DW-1:0] LAST_DRAIN = DW'(LAT - 1);
  localparam logic [DW-1:0] D_ONE      = {{(DW-1){1'b0}}, 1'b1};

  logic [1:0]    state, next_state;
  logic [N:0]    idx;
  logic [DW-1:0] drain_cnt;
  logic          stop_lat;
  logic          busy_nx, done_nx, vec_valid_nx;
  logic          flush, start_ok, mismatch;
  logic [N-1:0]  d_vec;
  logic          d_valid;
  logic [N:0]    count_nx;

  assign vec      = idx[N-1:0];
  assign flush    = abort && ((state == S_SWEEP) || (state == S_DRAIN));
  assign start_ok = (state == S_IDLE) && start && !abort;
  assign mismatch = d_valid && (q_a != q_b);

  // Delay line aligning each issued vector with the implementation outputs it produced
  generate
    if (LAT == 0) begin : g_no_pipe
      assign d_vec   = vec;
      assign d_valid = vec_valid;
    end else begin : g_pipe
      logic [N-1:0]   pipe_vec [LAT];
      logic [LAT-1:0] pipe_valid;
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= vec_valid;
          for (int i = 1; i < LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
        pipe_vec[0] <= vec;
        for (int i = 1; i < LAT; i++) pipe_vec[i] <= pipe_vec[i-1];
      end
      assign d_vec   = pipe_vec[LAT-1];
      assign d_valid = pipe_valid[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_valid <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= busy_nx;
      done      <= done_nx;
      vec_valid <= vec_valid_nx;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start_ok) next_state = S_SWEEP;
      S_SWEEP: begin
        if (abort)
          next_state = S_IDLE;
        else if ((idx == LAST_IDX) || (stop_lat && mismatch))
          next_state = (LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                       next_state = S_IDLE;
        else if (drain_cnt == LAST_DRAIN) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_nx      = (next_state == S_SWEEP) || (next_state == S_DRAIN);
    done_nx      = (next_state == S_DONE);
    vec_valid_nx = (next_state == S_SWEEP);
  end

  always_comb begin
    count_nx = mismatch_count;
    if (mismatch && (mismatch_count != MAX_COUNT)) count_nx = mismatch_count + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      drain_cnt      <= '0;
      stop_lat       <= 1'b0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_vec       <= '0;
      pass           <= 1'b0;
    end else if (start_ok) begin
      idx            <= '0;
      drain_cnt      <= '0;
      stop_lat       <= stop_on_fail;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_vec       <= '0;
      pass           <= 1'b0;
    end else begin
      if ((state == S_SWEEP) && !abort) idx <= idx + ONE;
      drain_cnt      <= (state == S_DRAIN) ? drain_cnt + D_ONE : '0;
      mismatch_count <= count_nx;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec   <= d_vec;
      end
      // Verdict uses the count including the final in-flight comparison
      if (next_state == S_DONE) pass <= (count_nx == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_equiv_sweep_ctrl.sv
`default_nettype none
// tb_equiv_sweep_ctrl: drives a LAT=0 and a LAT=2 controller in lockstep against truth-table
// implementations, checking hand-computed vectors, corner sequences and a randomized reference model.
module tb_equiv_sweep_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, sof;
  logic [7:0] ta, tb;

  logic [2:0] vec_o [2];
  logic       vv [2], busy_o [2], done_o [2], pass_o [2], fv_o [2];
  logic [2:0] fvec_o [2];
  logic [3:0] mc_o [2];
  logic       qa [2], qb [2];
  logic [1:0] ra, rb;

  always #5 clk = ~clk;

  assign qa[0] = ta[vec_o[0]];
  assign qb[0] = tb[vec_o[0]];
  always_ff @(posedge clk) begin
    ra <= {ra[0], ta[vec_o[1]]};
    rb <= {rb[0], tb[vec_o[1]]};
  end
  assign qa[1] = ra[1];
  assign qb[1] = rb[1];

  equiv_sweep_ctrl #(.N(3), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_fail(sof),
    .vec(vec_o[0]), .vec_valid(vv[0]), .q_a(qa[0]), .q_b(qb[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .fail_valid(fv_o[0]),
    .fail_vec(fvec_o[0]), .mismatch_count(mc_o[0])
  );

  equiv_sweep_ctrl #(.N(3), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_fail(sof),
    .vec(vec_o[1]), .vec_valid(vv[1]), .q_a(qa[1]), .q_b(qb[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .fail_valid(fv_o[1]),
    .fail_vec(fvec_o[1]), .mismatch_count(mc_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  int obs_done [2], obs_ndone [2], obs_issued [2], obs_seqbad [2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.d%0d.vec", tag, d), int'(vec_o[d]), 0);
      chk($sformatf("%s.d%0d.vec_valid", tag, d), int'(vv[d]), 0);
      chk($sformatf("%s.d%0d.busy", tag, d), int'(busy_o[d]), 0);
      chk($sformatf("%s.d%0d.done", tag, d), int'(done_o[d]), 0);
      chk($sformatf("%s.d%0d.pass", tag, d), int'(pass_o[d]), 0);
      chk($sformatf("%s.d%0d.fail_valid", tag, d), int'(fv_o[d]), 0);
      chk($sformatf("%s.d%0d.fail_vec", tag, d), int'(fvec_o[d]), 0);
      chk($sformatf("%s.d%0d.count", tag, d), int'(mc_o[d]), 0);
    end
  endtask

  // Start a sweep and observe 20 cycles; cycle c is the c-th cycle after the start edge.
  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input int extra_start);
    @(negedge clk);
    ta = a; tb = b; sof = s; start = 1'b1;
    for (int d = 0; d < 2; d++) begin
      obs_done[d] = -1; obs_ndone[d] = 0; obs_issued[d] = 0; obs_seqbad[d] = 0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == extra_start);
      sof   = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (vv[d]) begin
          if (int'(vec_o[d]) != c - 1 || obs_issued[d] != c - 1) obs_seqbad[d]++;
          obs_issued[d]++;
        end
        if (done_o[d]) begin
          obs_ndone[d]++;
          obs_done[d] = c;
        end
      end
    end
    start = 1'b0;
  endtask

  // Reference: derive the sweep outcome from the truth tables and the timing rules.
  task automatic check_model(input string tag, input int d, input int lat,
                             input logic [7:0] a, input logic [7:0] b, input logic s);
    int first, last_issue, exp_count, exp_done;
    logic [7:0] diff;
    diff  = a ^ b;
    first = -1;
    for (int k = 7; k >= 0; k--) if (diff[k]) first = k;
    last_issue = 7;
    exp_done   = 9 + lat;
    if (s && first >= 0 && first + lat < 7) begin
      last_issue = first + lat;
      exp_done   = first + 2 * lat + 2;
    end
    exp_count = 0;
    for (int k = 0; k <= last_issue; k++) if (diff[k]) exp_count++;
    chk($sformatf("%s.d%0d.done_cycle", tag, d), obs_done[d], exp_done);
    chk($sformatf("%s.d%0d.done_pulses", tag, d), obs_ndone[d], 1);
    chk($sformatf("%s.d%0d.issued", tag, d), obs_issued[d], last_issue + 1);
    chk($sformatf("%s.d%0d.seq_errors", tag, d), obs_seqbad[d], 0);
    chk($sformatf("%s.d%0d.count", tag, d), int'(mc_o[d]), exp_count);
    chk($sformatf("%s.d%0d.fail_valid", tag, d), int'(fv_o[d]), (first >= 0) ? 1 : 0);
    chk($sformatf("%s.d%0d.fail_vec", tag, d), int'(fvec_o[d]), (first >= 0) ? first : 0);
    chk($sformatf("%s.d%0d.pass", tag, d), int'(pass_o[d]), (exp_count == 0) ? 1 : 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    int         extra;
    int         done0, done2, cnt0, cnt2, issued0, fvec, fvalid, pass;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [7:0] ra_tab, rb_tab;
    logic       rs;

    // b & (a | c) with a = vec[2], b = vec[1], c = vec[0] -> ones at 3, 6, 7
    tbl[0] = '{8'hC8, 8'hC8, 1'b0, 3, 9, 11, 0, 0, 8, 0, 0, 1};
    tbl[1] = '{8'hC8, 8'hE8, 1'b0, 0, 9, 11, 1, 1, 8, 5, 1, 0};
    tbl[2] = '{8'hC8, 8'h8C, 1'b1, 0, 4,  8, 1, 1, 3, 2, 1, 0};
    tbl[3] = '{8'hC8, 8'h48, 1'b0, 0, 9, 11, 1, 1, 8, 7, 1, 0};
    tbl[4] = '{8'hC8, 8'h8C, 1'b0, 0, 9, 11, 2, 2, 8, 2, 1, 0};
    tbl[5] = '{8'h00, 8'hFF, 1'b1, 0, 2,  6, 1, 3, 1, 0, 1, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; sof = 1'b0; ta = '0; tb = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].extra);
      chk($sformatf("tbl%0d.done0", i), obs_done[0], tbl[i].done0);
      chk($sformatf("tbl%0d.done2", i), obs_done[1], tbl[i].done2);
      chk($sformatf("tbl%0d.issued0", i), obs_issued[0], tbl[i].issued0);
      chk($sformatf("tbl%0d.seq0", i), obs_seqbad[0], 0);
      chk($sformatf("tbl%0d.count0", i), int'(mc_o[0]), tbl[i].cnt0);
      chk($sformatf("tbl%0d.count2", i), int'(mc_o[1]), tbl[i].cnt2);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d.d%0d.fail_vec", i, d), int'(fvec_o[d]), tbl[i].fvec);
        chk($sformatf("tbl%0d.d%0d.fail_valid", i, d), int'(fv_o[d]), tbl[i].fvalid);
        chk($sformatf("tbl%0d.d%0d.pass", i, d), int'(pass_o[d]), tbl[i].pass);
      end
    end

    // abort while the LAT=0 controller shows vec=4
    @(negedge clk);
    ta = 8'hC8; tb = 8'hC8; sof = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.vec_at_abort", int'(vec_o[0]), 4);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort.d%0d.busy", d), int'(busy_o[d]), 0);
      chk($sformatf("abort.d%0d.vec_valid", d), int'(vv[d]), 0);
    end
    begin
      int dones;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) if (done_o[d] || busy_o[d]) dones++;
      end
      chk("abort.no_done_no_busy", dones, 0);
    end
    for (int d = 0; d < 2; d++) chk($sformatf("abort.d%0d.pass", d), int'(pass_o[d]), 0);
    run_sweep(8'hC8, 8'hC8, 1'b0, 0);
    check_model("after_abort", 0, 0, 8'hC8, 8'hC8, 1'b0);
    check_model("after_abort", 1, 2, 8'hC8, 8'hC8, 1'b0);

    // start and abort together in IDLE: no sweep
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("start_abort.d%0d.busy", d), int'(busy_o[d]), 0);
      chk($sformatf("start_abort.d%0d.pass_held", d), int'(pass_o[d]), 1);
    end

    // reset mid-sweep while vec=3, with mismatches already counted
    @(negedge clk);
    ta = 8'h00; tb = 8'h03; sof = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.vec_before", int'(vec_o[0]), 3);
    chk("rst.count_before", int'(mc_o[0]), 2);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;

    // randomized truth tables checked against the reference
    for (int it = 0; it < 24; it++) begin
      ra_tab = 8'($urandom);
      rb_tab = ra_tab ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rs     = 1'($urandom);
      run_sweep(ra_tab, rb_tab, rs, 0);
      check_model($sformatf("rnd%0d", it), 0, 0, ra_tab, rb_tab, rs);
      check_model($sformatf("rnd%0d", it), 1, 2, ra_tab, rb_tab, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
